ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage upstream of the single-cycle main control unit. Owns the PC.
//  Issues one instruction-memory read at a time and holds the returned word in an instruction register (IR).
//  Presents the IR to decode/control with a valid/ready handshake.
//  Computes the next PC from the control outputs (is_beq, jmp) and the ALU zero flag.
//  Those signals are sampled in the accept cycle.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; must be word aligned
//  PERF_CNT_W  32             width of the perf counters (IFETCH_PERF_EN only)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high reset
//  imem_req     out  1   one-cycle read request pulse
//  imem_addr    out  32  read address (= pc); stable from REQ until the response is captured
//  imem_rvalid  in   1   read data valid; at least 1 cycle after imem_req
//  imem_rdata   in   32  instruction word, qualified by imem_rvalid
//  instr        out  32  IR contents
//  opcode       out  6   instr[31:26], to the main control unit
//  instr_valid  out  1   IR holds an undelivered instruction
//  instr_ready  in   1   downstream accepts instr this cycle
//  pc           out  32  address of the instruction in IR
//  pc_plus4     out  32  pc + 4
//  is_beq       in   1   from control: current instruction is BEQ
//  jmp          in   1   from control: current instruction is J
//  alu_zero     in   1   from ALU: rs - rt == 0
//  fetch_cnt    out  PERF_CNT_W  instructions accepted (0 without IFETCH_PERF_EN)
//  stall_cnt    out  PERF_CNT_W  cycles with instr_valid & !instr_ready (0 without IFETCH_PERF_EN)
// BEHAVIOUR
//  Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, state=IDLE, counters=0.
//  Reset wins over every other event in the same cycle.
//  FSM:
//   IDLE  -> REQ: unconditional, one cycle after reset deasserts.
//   REQ   -> WAIT: drive imem_req=1 and imem_addr=pc for exactly this cycle.
//   WAIT  -> VALID: on imem_rvalid, capture IR <= imem_rdata. Otherwise stay in WAIT, with no timeout.
//   VALID -> REQ: on instr_ready, update pc <= next_pc. Otherwise hold IR and pc unchanged.
//  instr_valid = (state==VALID). Minimum fetch cycle: 3 clocks per instruction (REQ, WAIT, VALID).
//  imem_rvalid outside WAIT is ignored and the IR is not written.
//  next_pc, evaluated in the accept cycle only (32-bit, wrap-around mod 2^32, no trap):
//   jmp=1               : {pc_plus4[31:28], instr[25:0], 2'b00}
//   is_beq=1 & alu_zero : pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
//   otherwise           : pc_plus4
//  Priority: jmp > taken BEQ > sequential. If jmp and is_beq are both 1, the result is the jump target.
//  is_beq=1 with alu_zero=0 gives pc_plus4.
//  Reset mid-operation: the FSM returns to IDLE and any in-flight response is discarded.
//  The memory shares the same reset, so no stale rvalid can arrive after reset.
// CONFIGURATION
//  IFETCH_PERF_EN defined:
//   fetch_cnt increments on each accept.
//   stall_cnt increments each VALID cycle with !instr_ready.
//   Both saturate at all-ones and clear on reset.
//  IFETCH_PERF_EN undefined: no counter flops; fetch_cnt and stall_cnt are tied to 0.
// TESTING
//  1) Reset, memory returning rvalid 1 cycle after req:
//     -> first imem_req at cycle 2 after reset release, imem_addr=0.
//     -> instr_valid at cycle 4; pc=0, pc_plus4=4.
//  2) Three sequential non-branch instructions, instr_ready=1:
//     -> imem_addr goes 0, 4, 8; one accept every 3 cycles.
//  3) pc=0x40, BEQ imm=0xFFFF, is_beq=1, alu_zero=1 -> next fetch 0x40.
//     Repeat with imm=0x0003, alu_zero=0 -> next fetch 0x44.
//  4) pc=0x1000_0010, J with instr[25:0]=0x000_0100, jmp=1, is_beq=1, alu_zero=1
//     -> next fetch 0x1000_0400 (jump wins).
//  5) instr_ready=0 for 5 cycles in VALID -> instr and pc stable, no imem_req.
//     -> with IFETCH_PERF_EN: stall_cnt +5, then fetch_cnt +1 on accept.
//  6) reset asserted while in WAIT, with rvalid arriving in the same cycle
//     -> IR stays 0, instr_valid=0; refetch from RESET_PC.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Instruction-fetch bus bundle: instruction-memory read port, IR hand-off to decode,
// control/ALU feedback used for next-PC selection, and the optional perf counters.
interface ifetch_if #(
   parameter int PERF_CNT_W = 32
) ();
   // instr_valid/instr_ready: an instruction moves downstream on every clock edge where both
   // are high; valid never drops and instr/pc never change until that edge. imem_req is a
   // one-cycle pulse, and imem_rvalid qualifies imem_rdata only while a read is outstanding.
   logic                  imem_req;
   logic [31:0]           imem_addr;
   logic                  imem_rvalid;
   logic [31:0]           imem_rdata;
   logic [31:0]           instr;
   logic [5:0]            opcode;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [31:0]           pc;
   logic [31:0]           pc_plus4;
   logic                  is_beq;
   logic                  jmp;
   logic                  alu_zero;
   logic [PERF_CNT_W-1:0] fetch_cnt;
   logic [PERF_CNT_W-1:0] stall_cnt;

   modport master (
      output imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4,
             fetch_cnt, stall_cnt,
      input  imem_rvalid, imem_rdata, instr_ready, is_beq, jmp, alu_zero
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4,
             fetch_cnt, stall_cnt,
      output imem_rvalid, imem_rdata, instr_ready, is_beq, jmp, alu_zero
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time into the IR and hands it
// to decode. Define IFETCH_PERF_EN to build the saturating fetch/stall counters.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          PERF_CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   ifetch_if.master    bus,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] ir_q;
   logic        req_q;
   logic        valid_q;
   logic [31:0] pc_plus4;
   logic [31:0] br_off;
   logic        accept;

   assign accept = valid_q & bus.instr_ready;

   // Control inputs only describe the IR while it is being accepted; pc_d is consumed then.
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
      if (bus.jmp) begin
         pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      end else if (bus.is_beq && bus.alu_zero) begin
         pc_d = pc_plus4 + br_off;
      end else begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
            end
            S_REQ: begin
               state_q <= S_WAIT;
               req_q   <= 1'b0;
            end
            S_WAIT: begin
               if (bus.imem_rvalid) begin
                  ir_q    <= bus.imem_rdata;
                  state_q <= S_VALID;
                  valid_q <= 1'b1;
               end
            end
            S_VALID: begin
               if (bus.instr_ready) begin
                  pc_q    <= pc_d;
                  state_q <= S_REQ;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = ir_q;
   assign bus.opcode      = ir_q[31:26];
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign state_o         = state_q;

`ifdef IFETCH_PERF_EN
   logic [PERF_CNT_W-1:0] fetch_cnt_q;
   logic [PERF_CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept && (fetch_cnt_q != '1)) begin
            fetch_cnt_q <= fetch_cnt_q + 1'b1;
         end
         if (valid_q && !bus.instr_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   assign bus.fetch_cnt = fetch_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign bus.fetch_cnt = '0;
   assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: two instances (RESET_PC 0 and 0x1000_0004) share one memory model
// and handshake so jump targets can be checked with and without PC[31:28] set.
module tb_ifetch_unit;
   localparam int          W        = 32;
   localparam logic [31:0] PC2_BASE = 32'h1000_0004;
`ifdef IFETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // accepted-instruction table: word, pc of each instance, {jmp,is_beq,alu_zero}, stall cycles
   localparam logic [31:0] T_WORD [0:10] = '{
      32'h8C01_0000, 32'h0022_1820, 32'hAC02_0004, 32'h0800_0100, 32'h0800_0010,
      32'h1000_FFFF, 32'h1000_FFFF, 32'h1000_0003, 32'h1000_0003, 32'h3C01_FFFF,
      32'h8C01_0000};
   localparam logic [31:0] T_PC1 [0:10] = '{
      32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C, 32'h0000_0400,
      32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 32'h0000_0048, 32'h0000_0058,
      32'h0000_0000};
   localparam logic [31:0] T_PC2 [0:10] = '{
      32'h1000_0004, 32'h1000_0008, 32'h1000_000C, 32'h1000_0010, 32'h1000_0400,
      32'h1000_0040, 32'h1000_0040, 32'h1000_0044, 32'h1000_0048, 32'h1000_0058,
      32'h1000_0004};
   localparam logic [2:0] T_CTRL [0:10] = '{
      3'b000, 3'b000, 3'b000, 3'b111, 3'b100, 3'b011, 3'b010, 3'b010, 3'b011, 3'b000, 3'b000};
   localparam int T_DLY [0:10] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0};
   // every fetch address in order, including the 0x5C fetch killed by reset
   localparam logic [31:0] A_PC1 [0:12] = '{
      32'h0, 32'h4, 32'h8, 32'hC, 32'h400, 32'h40, 32'h40, 32'h44, 32'h48, 32'h58, 32'h5C,
      32'h0, 32'h4};
   localparam logic [31:0] A_PC2 [0:12] = '{
      32'h1000_0004, 32'h1000_0008, 32'h1000_000C, 32'h1000_0010, 32'h1000_0400,
      32'h1000_0040, 32'h1000_0040, 32'h1000_0044, 32'h1000_0048, 32'h1000_0058,
      32'h1000_005C, 32'h1000_0004, 32'h1000_0008};

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc1;
      logic [31:0] pc2;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  st1, st2;
   logic [31:0] exp_q [$];
   logic [31:0] exp2_q [$];
   acc_t        acc_q [$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          first_req_cyc = -1;
   int          first_valid_cyc = -1;
   int          acc_cyc [0:15];
   int          n_acc = 0;
   bit          abort = 1'b0;

   always #5 clk = ~clk;

   ifetch_if #(.PERF_CNT_W(W)) bus1 ();
   ifetch_if #(.PERF_CNT_W(W)) bus2 ();

   ifetch_unit #(.RESET_PC(32'h0), .PERF_CNT_W(W)) u_dut (
      .clk(clk), .reset(reset), .bus(bus1), .state_o(st1));
   ifetch_unit #(.RESET_PC(PC2_BASE), .PERF_CNT_W(W)) u_dut2 (
      .clk(clk), .reset(reset), .bus(bus2), .state_o(st2));

   assign bus2.imem_rvalid = bus1.imem_rvalid;
   assign bus2.imem_rdata  = bus1.imem_rdata;
   assign bus2.instr_ready = bus1.instr_ready;
   assign bus2.is_beq      = bus1.is_beq;
   assign bus2.jmp         = bus1.jmp;
   assign bus2.alu_zero    = bus1.alu_zero;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h8C01_0000;
         32'h0000_0004: return 32'h0022_1820;
         32'h0000_0008: return 32'hAC02_0004;
         32'h0000_000C: return 32'h0800_0100;
         32'h0000_0400: return 32'h0800_0010;
         32'h0000_0040: return 32'h1000_FFFF;
         32'h0000_0044: return 32'h1000_0003;
         32'h0000_0048: return 32'h1000_0003;
         32'h0000_0058: return 32'h3C01_FFFF;
         32'h0000_005C: return 32'hDEAD_BEEF;
         default:       return 32'hBAD0_BAD0;
      endcase
   endfunction

   // memory: answers each request exactly one cycle after it, served from instance 1's address
   initial begin : mem_model
      logic        m_req;
      logic [31:0] m_addr;
      logic        m_rst;
      bus1.imem_rvalid = 1'b0;
      bus1.imem_rdata  = 32'hBAD0_BAD0;
      forever begin
         @(negedge clk);
         m_req  = bus1.imem_req;
         m_addr = bus1.imem_addr;
         m_rst  = reset;
         @(posedge clk);
         #1;
         bus1.imem_rvalid = !m_rst && m_req;
         bus1.imem_rdata  = (!m_rst && m_req) ? mem_rd(m_addr) : 32'hBAD0_BAD0;
      end
   end

   always @(posedge clk) begin
      if (reset) cyc = 0;
      else cyc++;
   end

   // monitor: pops the scoreboard whenever a request or an accept is visible
   always @(negedge clk) begin
      if (!reset) begin
         if (bus1.imem_req) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            check("imem_req2", {31'd0, bus2.imem_req}, 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_req_addr", bus1.imem_addr, 32'hFFFF_FFFF);
            end else begin
               check("imem_addr", bus1.imem_addr, exp_q.pop_front());
               check("imem_addr2", bus2.imem_addr, exp2_q.pop_front());
            end
         end
         if (bus1.instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus1.instr_valid && bus1.instr_ready) begin
            if (acc_q.size() == 0) begin
               check("unexpected_accept", bus1.instr, 32'hFFFF_FFFF);
            end else begin
               acc_t e;
               e = acc_q.pop_front();
               check("instr", bus1.instr, e.word);
               check("opcode", {26'd0, bus1.opcode}, e.word >> 26);
               check("pc", bus1.pc, e.pc1);
               check("pc_plus4", bus1.pc_plus4, e.pc1 + 32'd4);
               check("pc2", bus2.pc, e.pc2);
               check("instr2", bus2.instr, e.word);
            end
            if (n_acc < 16) acc_cyc[n_acc] = cyc;
            n_acc++;
         end
      end
   end

   // drives one instruction through the handshake; called at posedge+1
   task automatic run_entry(input int i);
      int t = 0;
      acc_t e;
      while (!bus1.instr_valid && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!bus1.instr_valid) begin
         check("instr_valid_timeout", 32'd0, 32'd1);
         abort = 1'b1;
         return;
      end
      for (int k = 0; k < T_DLY[i]; k++) begin
         check("stall_instr", bus1.instr, T_WORD[i]);
         check("stall_pc", bus1.pc, T_PC1[i]);
         check("stall_no_req", {31'd0, bus1.imem_req}, 32'd0);
         @(posedge clk);
         #1;
      end
      e.word = T_WORD[i];
      e.pc1  = T_PC1[i];
      e.pc2  = T_PC2[i];
      acc_q.push_back(e);
      {bus1.jmp, bus1.is_beq, bus1.alu_zero} = T_CTRL[i];
      bus1.instr_ready = 1'b1;
      @(posedge clk);
      #1;
      bus1.instr_ready = 1'b0;
      {bus1.jmp, bus1.is_beq, bus1.alu_zero} = 3'b000;
   endtask

   initial begin
      int t;
      bus1.instr_ready = 1'b0;
      bus1.is_beq      = 1'b0;
      bus1.jmp         = 1'b0;
      bus1.alu_zero    = 1'b0;
      for (int i = 0; i < 13; i++) begin
         exp_q.push_back(A_PC1[i]);
         exp2_q.push_back(A_PC2[i]);
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_instr", bus1.instr, 32'd0);
      check("rst_valid", {31'd0, bus1.instr_valid}, 32'd0);
      check("rst_req", {31'd0, bus1.imem_req}, 32'd0);
      check("rst_pc", bus1.pc, 32'd0);
      check("rst_pc2", bus2.pc, PC2_BASE);
      check("rst_state", {30'd0, st1}, 32'd0);
      check("rst_fetch_cnt", bus1.fetch_cnt, 32'd0);
      check("rst_stall_cnt", bus1.stall_cnt, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 10 && !abort; i++) begin
         run_entry(i);
         if (!abort && i == 2) begin
            check("first_req_cycle", first_req_cyc + 1, 32'd2);
            check("first_valid_cycle", first_valid_cyc + 1, 32'd4);
            check("accept_gap_01", acc_cyc[1] - acc_cyc[0], 32'd3);
            check("accept_gap_12", acc_cyc[2] - acc_cyc[1], 32'd3);
         end
         if (!abort && i == 8) begin
            check("fetch_cnt_after_stall", bus1.fetch_cnt, PERF ? 32'd9 : 32'd0);
            check("stall_cnt_after_stall", bus1.stall_cnt, PERF ? 32'd5 : 32'd0);
         end
         if (!abort && i == 9) begin
            check("fetch_cnt_final", bus1.fetch_cnt, PERF ? 32'd10 : 32'd0);
         end
      end

      if (!abort) begin
         // reset lands while WAIT sees rvalid for the 0x5C fetch
         @(posedge clk);
         #2;
         check("pre_rst_state_wait", {30'd0, st1}, 32'd2);
         check("pre_rst_rvalid", {31'd0, bus1.imem_rvalid}, 32'd1);
         reset = 1'b1;
         @(posedge clk);
         #1;
         check("midrst_instr", bus1.instr, 32'd0);
         check("midrst_valid", {31'd0, bus1.instr_valid}, 32'd0);
         check("midrst_pc", bus1.pc, 32'd0);
         check("midrst_pc2", bus2.pc, PC2_BASE);
         check("midrst_state", {30'd0, st1}, 32'd0);
         check("midrst_fetch_cnt", bus1.fetch_cnt, 32'd0);
         @(posedge clk);
         #1;
         reset = 1'b0;
         run_entry(10);
         t = 0;
         while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
         end
         check("addr_queue_drained", exp_q.size(), 32'd0);
         check("accept_queue_drained", acc_q.size(), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
